// File: rtl/ibex_qed_regfile_ff_if.sv
// Bus bundle for the SQED flip-flop register file: read/write ports plus QED status.
// The regfile uses the slave modport; the WB stage / QED harness drives the master side.
interface ibex_qed_regfile_ff_if #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned AddrWidth = 5,
   parameter int unsigned CntWidth  = 16
);
   logic [AddrWidth-1:0] raddr_a_i;
   logic [DataWidth-1:0] rdata_a_o;
   logic [AddrWidth-1:0] raddr_b_i;
   logic [DataWidth-1:0] rdata_b_o;
   logic [AddrWidth-1:0] waddr_a_i;
   logic [DataWidth-1:0] wdata_a_i;
   logic                 we_a_i;
   logic                 qed_commit_i;
   logic                 qed_check_en_i;
   logic [CntWidth-1:0]  qed_orig_cnt_o;
   logic [CntWidth-1:0]  qed_dup_cnt_o;
   logic                 qed_ready_o;
   logic                 qed_busy_o;
   logic                 qed_check_vld_o;
   logic                 qed_mismatch_o;
   logic [AddrWidth-2:0] qed_mismatch_idx_o;
   logic                 qed_ovf_o;

   modport master (
      output raddr_a_i, raddr_b_i, waddr_a_i, wdata_a_i, we_a_i, qed_commit_i, qed_check_en_i,
      input  rdata_a_o, rdata_b_o, qed_orig_cnt_o, qed_dup_cnt_o, qed_ready_o, qed_busy_o,
             qed_check_vld_o, qed_mismatch_o, qed_mismatch_idx_o, qed_ovf_o
   );

   modport slave (
      input  raddr_a_i, raddr_b_i, waddr_a_i, wdata_a_i, we_a_i, qed_commit_i, qed_check_en_i,
      output rdata_a_o, rdata_b_o, qed_orig_cnt_o, qed_dup_cnt_o, qed_ready_o, qed_busy_o,
             qed_check_vld_o, qed_mismatch_o, qed_mismatch_idx_o, qed_ovf_o
   );
endinterface

// File: rtl/ibex_qed_regfile_ff.sv
// Flip-flop register file split into original/duplicate halves with SQED pair checking.
// Macro IBEX_QED_FULL_SCAN_EN selects a full pair scan; otherwise only the last duplicate pair.
module ibex_qed_regfile_ff #(
   parameter int unsigned          DataWidth   = 32,
   parameter int unsigned          AddrWidth   = 5,
   parameter int unsigned          CntWidth    = 16,
   parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
   input logic                  clk_i,
   input logic                  rst_i,
   ibex_qed_regfile_ff_if.slave bus
);
   localparam int unsigned NumWords = 2 ** AddrWidth;
   localparam int unsigned IdxWidth = AddrWidth - 1;

   typedef enum logic [1:0] {StIdle, StTrack, StCheck, StFail} state_e;

   state_e               state_q, state_d;
   logic [DataWidth-1:0] words_q [1:NumWords-1];
   logic [DataWidth-1:0] rf [NumWords];
   logic [CntWidth-1:0]  orig_cnt_q, orig_cnt_d;
   logic [CntWidth-1:0]  dup_cnt_q, dup_cnt_d;
   logic                 ovf_q, ovf_d;
   logic                 armed_q, armed_d;
   logic                 vld_q, vld_d;
   logic                 mismatch_q, mismatch_d;
   logic [IdxWidth-1:0]  mismatch_idx_q, mismatch_idx_d;
   logic [IdxWidth-1:0]  pair_idx;
   logic                 wr_en, cnt_en, cnt_orig, cnt_dup, ready, pair_eq;

   assign wr_en    = bus.we_a_i & (bus.waddr_a_i != '0);
   assign cnt_en   = wr_en & bus.qed_commit_i;
   assign cnt_dup  = cnt_en & bus.waddr_a_i[AddrWidth-1];
   assign cnt_orig = cnt_en & ~bus.waddr_a_i[AddrWidth-1];

   // Word 0 is a constant; the storage array only holds words 1..NumWords-1.
   always_comb begin
      rf[0] = WordZeroVal;
      for (int unsigned i = 1; i < NumWords; i++) rf[i] = words_q[i];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 1; i < NumWords; i++) words_q[i] <= WordZeroVal;
      end else if (wr_en) begin
         words_q[bus.waddr_a_i] <= bus.wdata_a_i;
      end
   end

   assign bus.rdata_a_o = rf[bus.raddr_a_i];
   assign bus.rdata_b_o = rf[bus.raddr_b_i];

   always_comb begin
      orig_cnt_d = orig_cnt_q;
      dup_cnt_d  = dup_cnt_q;
      if (cnt_orig && (orig_cnt_q != '1)) orig_cnt_d = orig_cnt_q + CntWidth'(1);
      if (cnt_dup && (dup_cnt_q != '1)) dup_cnt_d = dup_cnt_q + CntWidth'(1);
      ovf_d = ovf_q | (&orig_cnt_d) | (&dup_cnt_d);
   end

   assign ready   = (orig_cnt_q == dup_cnt_q) && (orig_cnt_q != '0);
   assign pair_eq = rf[{1'b0, pair_idx}] == rf[{1'b1, pair_idx}];

`ifdef IBEX_QED_FULL_SCAN_EN
   logic [IdxWidth-1:0] scan_q, scan_d;

   assign pair_idx = scan_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) scan_q <= '0;
      else       scan_q <= scan_d;
   end
`else
   logic [IdxWidth-1:0] last_dup_q, last_dup_d;

   assign pair_idx   = last_dup_q;
   assign last_dup_d = cnt_dup ? bus.waddr_a_i[IdxWidth-1:0] : last_dup_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) last_dup_q <= '0;
      else       last_dup_q <= last_dup_d;
   end
`endif

   always_comb begin
      state_d        = state_q;
      armed_d        = armed_q;
      vld_d          = 1'b0;
      mismatch_d     = mismatch_q;
      mismatch_idx_d = mismatch_idx_q;
`ifdef IBEX_QED_FULL_SCAN_EN
      scan_d         = scan_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (cnt_en) state_d = StTrack;
         end
         StTrack: begin
            if (ready && bus.qed_check_en_i && !ovf_q && armed_q) begin
               state_d = StCheck;
`ifdef IBEX_QED_FULL_SCAN_EN
               scan_d  = '0;
`endif
            end
         end
         StCheck: begin
            if (!pair_eq) begin
               mismatch_d     = 1'b1;
               mismatch_idx_d = pair_idx;
               state_d        = StFail;
`ifdef IBEX_QED_FULL_SCAN_EN
            end else if (&scan_q) begin
               vld_d   = 1'b1;
               armed_d = 1'b0;
               state_d = StTrack;
            end else begin
               scan_d  = scan_q + IdxWidth'(1);
            end
`else
            end else begin
               vld_d   = 1'b1;
               armed_d = 1'b0;
               state_d = StTrack;
            end
`endif
         end
         StFail: begin
            state_d = StFail;
         end
         default: state_d = StIdle;
      endcase
      // Any count change re-arms the checker, even one landing on the pass edge.
      if ((orig_cnt_d != orig_cnt_q) || (dup_cnt_d != dup_cnt_q)) armed_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= StIdle;
         orig_cnt_q     <= '0;
         dup_cnt_q      <= '0;
         ovf_q          <= 1'b0;
         armed_q        <= 1'b0;
         vld_q          <= 1'b0;
         mismatch_q     <= 1'b0;
         mismatch_idx_q <= '0;
      end else begin
         state_q        <= state_d;
         orig_cnt_q     <= orig_cnt_d;
         dup_cnt_q      <= dup_cnt_d;
         ovf_q          <= ovf_d;
         armed_q        <= armed_d;
         vld_q          <= vld_d;
         mismatch_q     <= mismatch_d;
         mismatch_idx_q <= mismatch_idx_d;
      end
   end

   assign bus.qed_orig_cnt_o     = orig_cnt_q;
   assign bus.qed_dup_cnt_o      = dup_cnt_q;
   assign bus.qed_ready_o        = ready;
   assign bus.qed_busy_o         = (state_q == StCheck);
   assign bus.qed_check_vld_o    = vld_q;
   assign bus.qed_mismatch_o     = mismatch_q;
   assign bus.qed_mismatch_idx_o = mismatch_idx_q;
   assign bus.qed_ovf_o          = ovf_q;
endmodule

// File: tb/tb_ibex_qed_regfile_ff.sv
// Scoreboard bench for ibex_qed_regfile_ff: pass/fail events are queued by the stimulus
// and matched by a monitor; a CntWidth=2 copy shares the stimulus for saturation.
module tb_ibex_qed_regfile_ff;
   localparam int H = 16;
`ifdef IBEX_QED_FULL_SCAN_EN
   localparam int LatPass = H;
   localparam int LatFail4 = 5;
   localparam int WrOff = 3;
`else
   localparam int LatPass = 1;
   localparam int LatFail4 = 1;
   localparam int WrOff = 1;
`endif

   typedef struct {
      bit         fail;
      logic [3:0] idx;
      int         cyc;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic mm_prev = 1'b0;
   ev_t  sb_q[$];

   ibex_qed_regfile_ff_if #(.DataWidth(32), .AddrWidth(5), .CntWidth(16)) m ();
   ibex_qed_regfile_ff_if #(.DataWidth(32), .AddrWidth(5), .CntWidth(2))  s ();

   ibex_qed_regfile_ff #(.DataWidth(32), .AddrWidth(5), .CntWidth(16), .WordZeroVal(32'h0))
      u_dut (.clk_i(clk), .rst_i(rst), .bus(m));
   ibex_qed_regfile_ff #(.DataWidth(32), .AddrWidth(5), .CntWidth(2), .WordZeroVal(32'h0))
      u_sat (.clk_i(clk), .rst_i(rst), .bus(s));

   assign s.raddr_a_i      = m.raddr_a_i;
   assign s.raddr_b_i      = m.raddr_b_i;
   assign s.waddr_a_i      = m.waddr_a_i;
   assign s.wdata_a_i      = m.wdata_a_i;
   assign s.we_a_i         = m.we_a_i;
   assign s.qed_commit_i   = m.qed_commit_i;
   assign s.qed_check_en_i = m.qed_check_en_i;

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every pass pulse or new mismatch must match the head of the scoreboard.
   initial forever begin
      @(negedge clk);
      if (m.qed_check_vld_o === 1'b1 || (m.qed_mismatch_o === 1'b1 && !mm_prev)) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: vld %0b mismatch %0b at cycle %0d, expected none",
                     m.qed_check_vld_o, m.qed_mismatch_o, cyc);
         end else begin
            ev_t e;
            e = sb_q.pop_front();
            chk("ev_kind", 64'({m.qed_check_vld_o, m.qed_mismatch_o}),
                64'(e.fail ? 2'b01 : 2'b10));
            if (e.fail) chk("ev_idx", 64'(m.qed_mismatch_idx_o), 64'(e.idx));
            chk("ev_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
      mm_prev = (m.qed_mismatch_o === 1'b1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic commit(input logic [4:0] a, input logic [31:0] d, input logic c);
      m.we_a_i       = 1'b1;
      m.waddr_a_i    = a;
      m.wdata_a_i    = d;
      m.qed_commit_i = c;
      tick();
      m.we_a_i       = 1'b0;
      m.qed_commit_i = 1'b0;
   endtask

   task automatic expect_ev(input bit f, input logic [3:0] idx, input int lat);
      ev_t e;
      e.fail = f;
      e.idx  = idx;
      e.cyc  = cyc + 1 + lat;
      sb_q.push_back(e);
   endtask

   task automatic wait_sb(input int budget);
      for (int i = 0; i < budget && sb_q.size() != 0; i++) tick();
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL sb_timeout: %0d events still pending, expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   initial begin
      logic seen;
      m.raddr_a_i = 5'd5;
      m.raddr_b_i = 5'd20;
      m.waddr_a_i = '0;
      m.wdata_a_i = '0;
      m.we_a_i = 1'b0;
      m.qed_commit_i = 1'b0;
      m.qed_check_en_i = 1'b0;
      do_reset();
      @(negedge clk);
      chk("rst_x5", 64'(m.rdata_a_o), 64'h0);
      chk("rst_x20", 64'(m.rdata_b_o), 64'h0);
      chk("rst_orig", 64'(m.qed_orig_cnt_o), 64'h0);
      chk("rst_dup", 64'(m.qed_dup_cnt_o), 64'h0);
      chk("rst_ready", 64'(m.qed_ready_o), 64'h0);
      chk("rst_busy", 64'(m.qed_busy_o), 64'h0);
      chk("rst_vld", 64'(m.qed_check_vld_o), 64'h0);
      chk("rst_mismatch", 64'(m.qed_mismatch_o), 64'h0);
      chk("rst_idx", 64'(m.qed_mismatch_idx_o), 64'h0);
      chk("rst_ovf", 64'(m.qed_ovf_o), 64'h0);

      // Writes to x0 are dropped and not counted.
      tick();
      commit(5'd0, 32'hFF, 1'b1);
      m.raddr_a_i = 5'd0;
      @(negedge clk);
      chk("x0_read", 64'(m.rdata_a_o), 64'h0);
      chk("x0_nocount", 64'(m.qed_orig_cnt_o), 64'h0);

      // Read of the word being written shows the old value.
      tick();
      m.raddr_a_i = 5'd3;
      m.we_a_i = 1'b1;
      m.waddr_a_i = 5'd3;
      m.wdata_a_i = 32'hA5;
      m.qed_commit_i = 1'b1;
      @(negedge clk);
      chk("rdw_old", 64'(m.rdata_a_o), 64'h0);
      tick();
      m.we_a_i = 1'b0;
      m.qed_commit_i = 1'b0;
      m.raddr_b_i = 5'd19;
      commit(5'd19, 32'hA5, 1'b1);
      @(negedge clk);
      chk("x3_read", 64'(m.rdata_a_o), 64'hA5);
      chk("x19_read", 64'(m.rdata_b_o), 64'hA5);
      chk("pair_orig", 64'(m.qed_orig_cnt_o), 64'h1);
      chk("pair_dup", 64'(m.qed_dup_cnt_o), 64'h1);
      chk("pair_ready", 64'(m.qed_ready_o), 64'h1);
      tick();
      m.qed_check_en_i = 1'b1;
      expect_ev(1'b0, 4'd0, LatPass);
      tick();
      m.qed_check_en_i = 1'b0;
      wait_sb(40);
      @(negedge clk);
      chk("pass_busy_done", 64'(m.qed_busy_o), 64'h0);

      // A write landing during the compare is not seen by the running check.
      tick();
      commit(5'd2, 32'h11, 1'b1);
      commit(5'd18, 32'h11, 1'b1);
      m.qed_check_en_i = 1'b1;
      expect_ev(1'b0, 4'd0, LatPass);
      tick();
      m.qed_check_en_i = 1'b0;
      repeat (WrOff - 1) tick();
      commit(5'd2, 32'h55, 1'b0);
      wait_sb(40);
      commit(5'd18, 32'h55, 1'b0);
      m.raddr_a_i = 5'd2;
      @(negedge clk);
      chk("wdc_x2", 64'(m.rdata_a_o), 64'h55);
      chk("wdc_dup_nocount", 64'(m.qed_dup_cnt_o), 64'h2);

      // Mismatching pair 4 sends the FSM to its terminal failure state.
      tick();
      commit(5'd4, 32'h1, 1'b1);
      commit(5'd20, 32'h2, 1'b1);
      m.qed_check_en_i = 1'b1;
      expect_ev(1'b1, 4'd4, LatFail4);
      tick();
      m.qed_check_en_i = 1'b0;
      wait_sb(40);
      repeat (3) tick();
      @(negedge clk);
      chk("fail_sticky", 64'(m.qed_mismatch_o), 64'h1);
      chk("fail_idx", 64'(m.qed_mismatch_idx_o), 64'h4);
      chk("fail_busy", 64'(m.qed_busy_o), 64'h0);
      tick();
      commit(5'd5, 32'h9, 1'b1);
      commit(5'd21, 32'h9, 1'b1);
      @(negedge clk);
      chk("fail_orig", 64'(m.qed_orig_cnt_o), 64'h4);
      chk("fail_dup", 64'(m.qed_dup_cnt_o), 64'h4);
      tick();
      m.qed_check_en_i = 1'b1;
      seen = 1'b0;
      repeat (4) begin
         tick();
         @(negedge clk);
         if (m.qed_busy_o !== 1'b0) seen = 1'b1;
      end
      m.qed_check_en_i = 1'b0;
      chk("fail_no_recheck", 64'(seen), 64'h0);

      // Saturation on the CntWidth=2 copy blocks any check.
      tick();
      do_reset();
      commit(5'd1, 32'h10, 1'b1);
      commit(5'd2, 32'h20, 1'b1);
      commit(5'd3, 32'h30, 1'b1);
      @(negedge clk);
      chk("sat_orig", 64'(s.qed_orig_cnt_o), 64'h3);
      chk("sat_ovf", 64'(s.qed_ovf_o), 64'h1);
      chk("wide_orig", 64'(m.qed_orig_cnt_o), 64'h3);
      chk("wide_ovf", 64'(m.qed_ovf_o), 64'h0);
      tick();
      commit(5'd17, 32'h10, 1'b1);
      commit(5'd18, 32'h20, 1'b1);
      commit(5'd19, 32'h30, 1'b1);
      @(negedge clk);
      chk("sat_dup", 64'(s.qed_dup_cnt_o), 64'h3);
      chk("sat_ready", 64'(s.qed_ready_o), 64'h1);
      tick();
      m.qed_check_en_i = 1'b1;
      expect_ev(1'b0, 4'd0, LatPass);
      seen = 1'b0;
      repeat (4) begin
         tick();
         @(negedge clk);
         if (s.qed_busy_o !== 1'b0 || s.qed_check_vld_o !== 1'b0) seen = 1'b1;
      end
      m.qed_check_en_i = 1'b0;
      chk("sat_no_check", 64'(seen), 64'h0);
      wait_sb(40);

      // Reset in the middle of a check: no pulse, no flag, everything cleared.
      do_reset();
      commit(5'd6, 32'h7, 1'b1);
      commit(5'd22, 32'h7, 1'b1);
      m.qed_check_en_i = 1'b1;
      tick();
      m.qed_check_en_i = 1'b0;
      @(negedge clk);
      chk("mid_busy", 64'(m.qed_busy_o), 64'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m.raddr_a_i = 5'd6;
      m.raddr_b_i = 5'd22;
      @(negedge clk);
      chk("mid_rst_busy", 64'(m.qed_busy_o), 64'h0);
      chk("mid_rst_orig", 64'(m.qed_orig_cnt_o), 64'h0);
      chk("mid_rst_dup", 64'(m.qed_dup_cnt_o), 64'h0);
      chk("mid_rst_vld", 64'(m.qed_check_vld_o), 64'h0);
      chk("mid_rst_mismatch", 64'(m.qed_mismatch_o), 64'h0);
      chk("mid_rst_x6", 64'(m.rdata_a_o), 64'h0);
      chk("mid_rst_x22", 64'(m.rdata_b_o), 64'h0);
      repeat (20) tick();
      chk("sb_drained", 64'(sb_q.size()), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1);
   end
endmodule
